// File: rtl/mem_io_responder_pkg.sv
// Shared types, address-map constants and small helpers for the memory/IO responder.
package mem_io_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 32;

    typedef logic [BYTE_W-1:0] byte_tp;
    typedef logic [ADDR_W-1:0] addr_tp;

    localparam int DEF_RAM_ADDR_W  = 17;
    localparam int DEF_TX_DEPTH    = 8;
    localparam int DEF_FULL_MARGIN = 2;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_OFF_UART = 3'd0;
    localparam logic [2:0] IO_OFF_CLK  = 3'd4;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_IO   = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

    // sel is addr[17:16]; the lower half of the 256 KB map is RAM.
    function automatic region_e decode_region(input logic [1:0] sel);
        region_e r;
        if (!sel[1]) begin
            r = REGION_RAM;
        end else if (sel == IO_SEL) begin
            r = REGION_IO;
        end else begin
            r = REGION_NONE;
        end
        return r;
    endfunction

    function automatic byte_tp word_byte(input logic [31:0] w, input logic [1:0] sel);
        byte_tp b;
        case (sel)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus: address/write strobe/data out of the CPU, read data and back-pressure in.
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    addr_tp mem_a;
    logic   mem_wr;
    byte_tp mem_wr_byte;
    byte_tp mem_rd_byte;
    logic   io_buffer_full;

    modport master (
        output mem_a,
        output mem_wr,
        output mem_wr_byte,
        input  mem_rd_byte,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_wr,
        input  mem_wr_byte,
        output mem_rd_byte,
        output io_buffer_full
    );

endinterface

// File: rtl/mem_io_responder_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; simultaneous push and pop allowed, even when full.
module mem_io_responder_tx_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH = DEF_TX_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  byte_tp           push_data,
    input  logic             pop,
    output byte_tp           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;
    byte_tp           slots [DEPTH];

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A pop in the same cycle frees the slot the push needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            byte_tp slot_reg;
            always_ff @(posedge clk_in) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    slot_reg <= push_data;
                end
            end
            assign slots[gi] = slot_reg;
        end
    endgenerate

    assign head = slots[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Far-end target of the CPU byte bus: 128 KB RAM plus an IO window with UART TX/RX,
// a free-running cycle counter and the program-stop register.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W  = DEF_RAM_ADDR_W,
    parameter int TX_DEPTH    = DEF_TX_DEPTH,
    parameter int FULL_MARGIN = DEF_FULL_MARGIN
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    mem_io_responder_if.slave    bus,
    output byte_tp               tx_byte,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  byte_tp               rx_byte,
    input  logic                 rx_valid,
    output logic                 rx_pop,
    output logic                 halt,
    output logic                 tx_overflow
);

    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    region_e               region;
    logic [2:0]            io_off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  ram_we;
    logic                  ram_re;
    logic                  io_wr;
    logic                  io_rd;
    logic                  unused_addr_bits;

    assign region  = decode_region(bus.mem_a[17:16]);
    assign io_off  = bus.mem_a[2:0];
    assign ram_idx = bus.mem_a[RAM_ADDR_W-1:0];
    assign ram_we  = bus.mem_wr && (region == REGION_RAM);
    assign ram_re  = !bus.mem_wr && (region == REGION_RAM);
    assign io_wr   = bus.mem_wr && (region == REGION_IO);
    assign io_rd   = !bus.mem_wr && (region == REGION_IO);

    assign unused_addr_bits = ^bus.mem_a[31:18];

    // ---------------------------------------------------------------- RAM
    byte_tp ram [2**RAM_ADDR_W];
    byte_tp ram_q_reg;

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.mem_wr_byte;
        end
        if (ram_re) begin
            ram_q_reg <= ram[ram_idx];
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic             tx_push;
    byte_tp           tx_push_data;
    logic             tx_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             halt_write;

    assign halt_write   = io_wr && (io_off == IO_OFF_CLK);
    // The stop register enqueues a 0x00 terminator so the host sees end-of-output.
    assign tx_push      = (io_wr && (io_off == IO_OFF_UART) && (bus.mem_wr_byte != 8'h00)) || halt_write;
    assign tx_push_data = halt_write ? 8'h00 : bus.mem_wr_byte;
    assign tx_valid     = !fifo_empty;
    assign tx_pop       = tx_valid && tx_ready;

    mem_io_responder_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_byte),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.io_buffer_full = (fifo_count >= CNT_W'(TX_DEPTH - FULL_MARGIN));

    // ---------------------------------------------------------------- IO read mux
    logic [31:0] cycle_cnt_reg;
    logic [31:0] snap_reg;
    byte_tp      io_rd_data;
    logic        snap_load;

    always_comb begin
        io_rd_data = '0;
        snap_load  = 1'b0;
        rx_pop     = 1'b0;
        if (io_rd) begin
            if (io_off == IO_OFF_UART) begin
                if (rx_valid) begin
                    io_rd_data = rx_byte;
                    rx_pop     = 1'b1;
                end
            end else if (io_off[2]) begin
                // Byte 0 comes live and freezes the rest so a 4-byte read is coherent.
                if (io_off[1:0] == 2'd0) begin
                    io_rd_data = cycle_cnt_reg[7:0];
                    snap_load  = 1'b1;
                end else begin
                    io_rd_data = word_byte(snap_reg, io_off[1:0]);
                end
            end
        end
    end

    // ---------------------------------------------------------------- control state
    logic   rd_sel_ram_reg;
    byte_tp io_q_reg;
    logic   halt_req_reg;
    logic   halt_reg;
    logic   overflow_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_sel_ram_reg <= 1'b0;
            io_q_reg       <= '0;
            cycle_cnt_reg  <= '0;
            snap_reg       <= '0;
            halt_req_reg   <= 1'b0;
            halt_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            // Write cycles leave the read-data path untouched so mem_rd_byte holds.
            if (!bus.mem_wr) begin
                rd_sel_ram_reg <= (region == REGION_RAM);
                io_q_reg       <= io_rd_data;
            end
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (snap_load) begin
                snap_reg <= cycle_cnt_reg;
            end
            if (halt_write) begin
                halt_req_reg <= 1'b1;
            end
            halt_reg <= halt_req_reg && fifo_empty;
            if (tx_push && fifo_full && !tx_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.mem_rd_byte = rd_sel_ram_reg ? ram_q_reg : io_q_reg;
    assign halt            = halt_reg;
    assign tx_overflow     = overflow_reg;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed vector table, hand sequences for FIFO/counter/halt, and a
// randomized run checked against a queue-based reference model.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       rx_pop;
    logic       halt;
    logic       tx_overflow;

    mem_io_responder_if bus();

    mem_io_responder #(
        .RAM_ADDR_W  (17),
        .TX_DEPTH    (DEPTH),
        .FULL_MARGIN (MARGIN)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .bus         (bus),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_pop      (rx_pop),
        .halt        (halt),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_ram     [0:131071];
    bit          m_written [0:131071];
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_halt_req;
    bit          m_halt;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  m_rd;
    bit          m_rd_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = unmapped, 2 = IO
    function automatic int region_of(input logic [31:0] a);
        logic [31:0] low;
        low = a % 32'h40000;
        if (low < 32'h20000) return 0;
        if (low >= 32'h30000) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 0;
        m_halt_req = 0;
        m_halt     = 0;
        m_cnt      = 0;
        m_snap     = 0;
        m_rd       = 8'h00;
        m_rd_known = 1;
    endtask

    task automatic cycle(input logic [31:0] a, input bit wr, input logic [7:0] wd,
                         input bit rdy, input bit rxv, input logic [7:0] rxb);
        int         r;
        int         off;
        int         idx;
        bit         pop;
        bit         push;
        bit         hn;
        bit         exp_pop;
        logic [7:0] pdata;
        bus.mem_a       = a;
        bus.mem_wr      = wr;
        bus.mem_wr_byte = wd;
        tx_ready        = rdy;
        rx_valid        = rxv;
        rx_byte         = rxb;
        r   = region_of(a);
        off = int'(a % 32'd8);
        idx = int'(a % 32'h20000);
        exp_pop = (r == 2) && !wr && (off == 0) && rxv;
        #1;
        chk("rx_pop", 32'(rx_pop), 32'(exp_pop));
        @(posedge clk);
        pop   = (m_q.size() > 0) && rdy;
        hn    = m_halt_req && (m_q.size() == 0);
        push  = 0;
        pdata = 8'h00;
        if (wr) begin
            if (r == 0) begin
                m_ram[idx]     = wd;
                m_written[idx] = 1;
            end else if (r == 2) begin
                if (off == 0 && wd != 8'h00) begin
                    push  = 1;
                    pdata = wd;
                end else if (off == 4) begin
                    push       = 1;
                    pdata      = 8'h00;
                    m_halt_req = 1;
                end
            end
        end else begin
            m_rd_known = 1;
            if (r == 0) begin
                m_rd_known = m_written[idx];
                m_rd       = m_ram[idx];
            end else if (r == 2) begin
                if (off == 0)      m_rd = rxv ? rxb : 8'h00;
                else if (off == 4) begin
                    m_rd   = 8'(m_cnt % 256);
                    m_snap = m_cnt;
                end
                else if (off > 4)  m_rd = 8'(m_snap >> (8 * (off - 4)));
                else               m_rd = 8'h00;
            end else begin
                m_rd = 8'h00;
            end
        end
        if (push && m_q.size() == DEPTH && !pop) begin
            m_ovf = 1;
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(pdata);
        end
        m_halt = hn;
        m_cnt  = m_cnt + 32'd1;
        #1;
        if (m_rd_known) chk("mem_rd_byte", 32'(bus.mem_rd_byte), 32'(m_rd));
        chk("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("tx_byte", 32'(tx_byte), 32'(m_q[0]));
        chk("io_buffer_full", 32'(bus.io_buffer_full), 32'(m_q.size() >= DEPTH - MARGIN));
        chk("halt", 32'(halt), 32'(m_halt));
        chk("tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    endtask

    task automatic idle_inputs();
        bus.mem_a       = 32'h10;
        bus.mem_wr      = 1'b0;
        bus.mem_wr_byte = 8'h00;
        tx_ready        = 1'b0;
        rx_valid        = 1'b0;
        rx_byte         = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] a;
        bit          wr;
        logic [7:0]  wd;
        bit          rdy;
        bit          rxv;
        logic [7:0]  rxb;
        bit          chk_rd;
        logic [7:0]  exp_rd;
        bit          exp_txv;
        logic [7:0]  exp_txb;
        bit          exp_pop;
    } vec_t;

    function automatic vec_t mk(logic [31:0] a, bit wr, logic [7:0] wd, bit rdy, bit rxv,
                                logic [7:0] rxb, bit chk_rd, logic [7:0] exp_rd, bit exp_txv,
                                logic [7:0] exp_txb, bit exp_pop);
        vec_t v;
        v.a = a; v.wr = wr; v.wd = wd; v.rdy = rdy; v.rxv = rxv; v.rxb = rxb;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_txv = exp_txv; v.exp_txb = exp_txb;
        v.exp_pop = exp_pop;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [16];
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] a;

        idle_inputs();
        //          addr           wr wd     rdy rxv rxb   chk rd     txv txb    pop
        vecs[0]  = mk(32'h00010,    1, 8'hA5, 1,  0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(32'h00010,    0, 8'h00, 1,  0, 8'h00, 1, 8'hA5, 0, 8'h00, 0);
        vecs[2]  = mk(32'h00011,    0, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        vecs[3]  = mk(32'h30000,    1, 8'h48, 0,  0, 8'h00, 0, 8'h00, 1, 8'h48, 0);
        vecs[4]  = mk(32'h30000,    1, 8'h69, 0,  0, 8'h00, 0, 8'h00, 1, 8'h48, 0);
        vecs[5]  = mk(32'h30000,    1, 8'h00, 1,  0, 8'h00, 0, 8'h00, 1, 8'h69, 0);
        vecs[6]  = mk(32'h00010,    0, 8'h00, 1,  0, 8'h00, 1, 8'hA5, 0, 8'h00, 0);
        vecs[7]  = mk(32'h30000,    0, 8'h00, 0,  1, 8'h37, 1, 8'h37, 0, 8'h00, 1);
        vecs[8]  = mk(32'h30000,    0, 8'h00, 0,  0, 8'h37, 1, 8'h00, 0, 8'h00, 0);
        vecs[9]  = mk(32'h00010,    0, 8'h00, 0,  0, 8'h00, 1, 8'hA5, 0, 8'h00, 0);
        vecs[10] = mk(32'h20005,    0, 8'h00, 0,  0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        vecs[11] = mk(32'h20010,    1, 8'h55, 0,  0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        vecs[12] = mk(32'h00010,    0, 8'h00, 0,  0, 8'h00, 1, 8'hA5, 0, 8'h00, 0);
        vecs[13] = mk(32'h30002,    0, 8'h00, 0,  0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        vecs[14] = mk(32'h30001,    1, 8'h41, 0,  0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        vecs[15] = mk(32'hFFC00010, 0, 8'h00, 0,  0, 8'h00, 1, 8'hA5, 0, 8'h00, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_mem_rd_byte", 32'(bus.mem_rd_byte), 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_buffer_full", 32'(bus.io_buffer_full), 32'h0);
        chk("reset_halt", 32'(halt), 32'h0);
        chk("reset_overflow", 32'(tx_overflow), 32'h0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].a, vecs[i].wr, vecs[i].wd, vecs[i].rdy, vecs[i].rxv, vecs[i].rxb);
            $display("vec %0d addr=%h wr=%0d wd=%h rd=%h txv=%0d txb=%h pop=%0d", i, vecs[i].a,
                     vecs[i].wr, vecs[i].wd, bus.mem_rd_byte, tx_valid, tx_byte, rx_pop);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), 32'(bus.mem_rd_byte), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_txv", i), 32'(tx_valid), 32'(vecs[i].exp_txv));
            if (vecs[i].exp_txv) chk($sformatf("vec%0d_txb", i), 32'(tx_byte), 32'(vecs[i].exp_txb));
            chk($sformatf("vec%0d_pop", i), 32'(rx_pop), 32'(vecs[i].exp_pop));
            chk($sformatf("vec%0d_ovf", i), 32'(tx_overflow), 32'h0);
        end

        // FIFO fill, near-full threshold and overflow with the UART stalled
        for (int i = 1; i <= 9; i++) begin
            cycle(32'h30000, 1, 8'(i), 0, 0, 8'h00);
            $display("push %0d count_full=%0d ovf=%0d", i, bus.io_buffer_full, tx_overflow);
            if (i == 5) chk("ibf_after_5", 32'(bus.io_buffer_full), 32'h0);
            if (i == 6) chk("ibf_after_6", 32'(bus.io_buffer_full), 32'h1);
            if (i == 8) chk("ovf_after_8", 32'(tx_overflow), 32'h0);
            if (i == 9) chk("ovf_after_9", 32'(tx_overflow), 32'h1);
        end
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_head_%0d", k), 32'(tx_byte), 32'(k));
            cycle(32'h00010, 0, 8'h00, 1, 0, 8'h00);
            $display("drain %0d txv=%0d", k, tx_valid);
        end
        chk("drained_empty", 32'(tx_valid), 32'h0);
        chk("ovf_sticky", 32'(tx_overflow), 32'h1);

        // Coherent 4-byte counter reads
        do_reset();
        repeat (300) cycle(32'h00010, 0, 8'h00, 0, 0, 8'h00);
        val1 = '0;
        for (int b = 0; b < 4; b++) begin
            cycle(32'h30004 + 32'(b), 0, 8'h00, 0, 0, 8'h00);
            val1 = val1 | (32'(bus.mem_rd_byte) << (8 * b));
        end
        $display("clock read 1 = %0d", val1);
        chk("clock_read1", val1, 32'd300);
        repeat (50) cycle(32'h00010, 0, 8'h00, 0, 0, 8'h00);
        val2 = '0;
        for (int b = 0; b < 4; b++) begin
            cycle(32'h30004 + 32'(b), 0, 8'h00, 0, 0, 8'h00);
            val2 = val2 | (32'(bus.mem_rd_byte) << (8 * b));
        end
        $display("clock read 2 = %0d", val2);
        chk("clock_read2", val2, 32'd354);
        chk("clock_monotonic", 32'(val2 > val1), 32'h1);

        // Program stop: terminator drains, then halt one cycle later
        do_reset();
        cycle(32'h30000, 1, 8'h58, 0, 0, 8'h00);
        cycle(32'h30004, 1, 8'h00, 0, 0, 8'h00);
        chk("halt_pending", 32'(halt), 32'h0);
        chk("halt_head_x", 32'(tx_byte), 32'h58);
        cycle(32'h00010, 0, 8'h00, 1, 0, 8'h00);
        chk("halt_head_term", 32'(tx_byte), 32'h00);
        chk("halt_term_valid", 32'(tx_valid), 32'h1);
        cycle(32'h00010, 0, 8'h00, 1, 0, 8'h00);
        chk("halt_not_yet", 32'(halt), 32'h0);
        chk("halt_fifo_empty", 32'(tx_valid), 32'h0);
        cycle(32'h00010, 0, 8'h00, 1, 0, 8'h00);
        chk("halt_rises", 32'(halt), 32'h1);
        cycle(32'h30000, 1, 8'h51, 0, 0, 8'h00);
        $display("pre-reset halt=%0d txv=%0d", halt, tx_valid);

        // Asynchronous reset mid-sequence clears state without waiting for a clock
        rst_n = 1'b0;
        #1;
        chk("areset_halt", 32'(halt), 32'h0);
        chk("areset_tx_valid", 32'(tx_valid), 32'h0);
        chk("areset_ibf", 32'(bus.io_buffer_full), 32'h0);
        chk("areset_rd", 32'(bus.mem_rd_byte), 32'h0);
        idle_inputs();
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cycle(32'h30004, 0, 8'h00, 0, 0, 8'h00);
        chk("counter_cleared", 32'(bus.mem_rd_byte), 32'h0);
        cycle(32'h30005, 0, 8'h00, 0, 0, 8'h00);
        chk("snapshot_cleared", 32'(bus.mem_rd_byte), 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 16; i++) cycle(32'h100 + 32'(i), 1, 8'($urandom), 0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            a   = $urandom & 32'hFFFC_0000;
            if (sel < 4)      a = a | (32'h100 + 32'($urandom_range(0, 15)));
            else if (sel < 8) a = a | 32'h30000 | (32'($urandom_range(0, 8191)) << 3) | 32'($urandom_range(0, 7));
            else              a = a | 32'h20000 | ($urandom & 32'hFFFF);
            cycle(a, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory/IO responder at the far end of the CPU's byte-wide memory bus (address/write-data/write-enable in, read-data and buffer-full out). It serves a 128 KB byte RAM with one-cycle read latency and decodes the IO window (addr[17:16]==2'b11). The IO window covers a UART TX FIFO, an RX byte port, a free-running clock counter and the program-stop register. It is the target the CPU core's memory controller talks to in simulation and on the FPGA top.

Parameters:
RAM_ADDR_W, 17, byte-address width of RAM (2^17 bytes).
TX_DEPTH, 8, TX FIFO entries; power of two, >=4.
FULL_MARGIN, 2, io_buffer_full asserts when free TX slots <= FULL_MARGIN, covering CPU writes already in flight.

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
mem_a  in  32  byte address from CPU; only [17:0] decoded
mem_wr  in  1  1 = write, 0 = read
mem_wr_byte  in  8  write data (CPU mem_dout)
mem_rd_byte  out  8  read data (CPU mem_din), valid the cycle after the read
io_buffer_full  out  1  TX FIFO near-full, to CPU
tx_byte  out  8  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART accepts tx_byte this cycle
rx_byte  in  8  received UART byte
rx_valid  in  1  rx_byte holds an unread byte
rx_pop  out  1  one-cycle pulse: rx_byte consumed
halt  out  1  program stop requested and TX drained
tx_overflow  out  1  sticky: a TX write was dropped

Behaviour:
- Reset (rst_in low, async): mem_rd_byte=0, FIFO empty (tx_valid=0, io_buffer_full=0), rx_pop=0, halt=0, tx_overflow=0, cycle counter=0, clock snapshot=0, halt_req=0. RAM contents are not reset.
- Decode: RAM when addr[17]==0, index addr[16:0]. IO when addr[17:16]==2'b11, offset addr[2:0]. addr[17:16]==2'b10 is unmapped: writes ignored, reads return 0.
- RAM write: mem_wr=1 → ram[idx] <= mem_wr_byte at the posedge.
- RAM read: mem_wr=0 → mem_rd_byte <= ram[idx] at the posedge, so data is visible in cycle N+1. There is no read-during-write forwarding, because a cycle carries only one access.
- mem_rd_byte holds its last value on write cycles.
- IO write, offset 0: a nonzero byte is pushed to the TX FIFO; 0x00 is ignored. If the FIFO is full, the byte is dropped and tx_overflow is set.
- IO write, offset 4: halt_req is set (sticky) and 0x00 is pushed to the FIFO as the terminator (dropped with tx_overflow if full).
- IO write, any other offset: ignored.
- halt = halt_req AND FIFO empty, registered, so it rises 1 cycle after the last byte pops.
- IO read, offset 0: if rx_valid, mem_rd_byte <= rx_byte and rx_pop pulses in the same cycle as the read request. Otherwise mem_rd_byte <= 0 and no pop.
- IO read, offsets 4..7: the clock counter is returned little-endian, byte addr[1:0]. Reading offset 4 latches a snapshot of the counter and returns byte 0 of the current value. Offsets 5..7 return the snapshot bytes 1..3, so a 4-byte read is coherent.
- IO read, other offsets: return 0.
- Cycle counter: 32 bits, increments every clock after reset and wraps 0xFFFFFFFF → 0.
- TX FIFO: push and pop may happen in the same cycle.
  - Push+pop on a full FIFO is accepted and the count is unchanged.
  - Pop occurs when tx_valid && tx_ready.
  - tx_byte always shows the head entry.
  - Pointers wrap modulo TX_DEPTH; the count is (log2 TX_DEPTH)+1 bits.
- io_buffer_full = (count >= TX_DEPTH - FULL_MARGIN), driven from registered count only; no comb path from mem_* inputs.
- All state is clocked by clk_in. The block has no stall input; the CPU withholds requests while paused.

Decomposition:
- Shared package: IO_SEL value 2'b11, IO_OFF_UART=3'd0, IO_OFF_CLK=3'd4, BYTE_TP/ADDR_TP width macros, default TX_DEPTH.
- Sub-module tx_fifo: synchronous FIFO with push/pop/full/empty/count outputs, parameter DEPTH.
- RAM is an inferred array inside mem_io_responder.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 → mem_rd_byte=0xA5 exactly one cycle after the read cycle. A read of 0x00011 (never written) does not disturb the 0xA5 result.
- Write 'H' (0x48) and 'i' (0x69) to 0x30000, then 0x00, with tx_ready=1 → tx_byte shows 0x48 then 0x69; the 0x00 never appears; tx_overflow=0.
- Hold tx_ready=0 and push 6 bytes (TX_DEPTH=8, FULL_MARGIN=2) → io_buffer_full rises after the 6th push. Push 3 more → the 9th is dropped and tx_overflow=1.
- Release after 300 cycles and read 0x30004..0x30007 on consecutive cycles → the four bytes assemble to the counter value at the offset-4 read (approx 0x12C + reset offset), monotonic across two such reads.
- rx_valid=1, rx_byte=0x37, read 0x30000 → rx_pop pulses once and mem_rd_byte=0x37 next cycle. With rx_valid=0 → 0x00 and no pop.
- Push 'X', write 0x30004 with tx_ready=0, then set tx_ready=1 → pops 'X' then 0x00; halt rises 1 cycle after the FIFO empties. Asserting rst_in low mid-sequence clears halt, the FIFO and the counter immediately.
